// File: rtl/control_sequencer_if.sv
// +-----------------------------------------------------------------------------+
// | Module      : control_sequencer_if                                          |
// | Description : IR/flag/handshake inputs and control/status outputs of the    |
// |               control sequencer, grouped as one bundle.                     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface control_sequencer_if;
    logic        run;
    logic        step;
    logic [3:0]  opcode;
    logic [2:0]  cond;
    logic        flag_zero;
    logic        flag_carry;
    logic        mem_ready;
    logic        io_ready;
    logic [15:0] ctrl;
    logic [4:0]  state_o;
    logic        busy;
    logic        fault;

    // master: the datapath/IR side that feeds the sequencer
    modport master (
        output run, step, opcode, cond, flag_zero, flag_carry, mem_ready, io_ready,
        input  ctrl, state_o, busy, fault
    );

    // slave: the sequencer itself
    modport slave (
        input  run, step, opcode, cond, flag_zero, flag_carry, mem_ready, io_ready,
        output ctrl, state_o, busy, fault
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module      : control_sequencer                                             |
// | Description : CPU fetch/decode/execute sequencer with memory/IO wait-state  |
// |               handshakes, wait timeout fault, halt and single-step.         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module control_sequencer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5,
    parameter int STEP_EN    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    control_sequencer_if.slave bus
);

    typedef enum logic [4:0] {
        S_IDLE       = 5'd0,
        S_FETCH_PC   = 5'd1,
        S_FETCH_INST = 5'd2,
        S_DECODE     = 5'd3,
        S_ALU_EXEC   = 5'd4,
        S_ALU_OUT    = 5'd5,
        S_SET_MAR    = 5'd6,
        S_SET_REG    = 5'd7,
        S_SET_MEM    = 5'd8,
        S_MOVE_REG   = 5'd9,
        S_JUMP       = 5'd10,
        S_MOUT_STORE = 5'd11,
        S_ROUT_STORE = 5'd12,
        S_HALT       = 5'd13,
        S_FAULT      = 5'd14
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_MOUT = 4'h6;
    localparam logic [3:0] OP_ROUT = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int B_II   = 0;
    localparam int B_CI   = 1;
    localparam int B_CO   = 2;
    localparam int B_CS   = 3;
    localparam int B_RFI  = 4;
    localparam int B_RFO  = 5;
    localparam int B_EO   = 6;
    localparam int B_EE   = 7;
    localparam int B_MI   = 8;
    localparam int B_RO   = 9;
    localparam int B_RI   = 10;
    localparam int B_DA   = 11;
    localparam int B_GO   = 12;
    localparam int B_HALT = 13;

    localparam logic [CNT_W-1:0] c_last_wait = CNT_W'(WAIT_LIMIT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fault;
    logic [3:0]       r_op;
    logic             r_first;

    logic             w_ja;
    logic             w_wait;
    logic             w_ready;
    logic             w_step_hold;
    logic [15:0]      w_ctrl;

    always_comb begin
        w_ja = 1'b0;
        case (bus.cond)
            3'd0:    w_ja = 1'b1;
            3'd1:    w_ja = bus.flag_carry;
            3'd2:    w_ja = ~bus.flag_carry;
            3'd3:    w_ja = bus.flag_zero;
            3'd4:    w_ja = ~bus.flag_zero;
            default: w_ja = 1'b0;
        endcase
    end

    // Which states wait on a handshake, and which ready releases them.
    always_comb begin
        w_wait  = 1'b0;
        w_ready = 1'b1;
        case (r_state)
            S_FETCH_INST, S_SET_REG, S_SET_MEM: begin
                w_wait  = 1'b1;
                w_ready = bus.mem_ready;
            end
            S_JUMP: begin
                w_wait  = w_ja;
                w_ready = bus.mem_ready;
            end
            S_MOUT_STORE: begin
                w_wait  = 1'b1;
                w_ready = bus.mem_ready & bus.io_ready;
            end
            S_ROUT_STORE: begin
                w_wait  = 1'b1;
                w_ready = bus.io_ready;
            end
            default: begin
                w_wait  = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    // The first FETCH_PC after leaving IDLE never waits for a step pulse.
    assign w_step_hold = (STEP_EN != 0) & ~r_first & ~bus.step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_op    <= 4'h0;
            r_first <= 1'b0;
        end else if (w_wait && !w_ready) begin
            if (r_cnt == c_last_wait) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state <= S_FETCH_PC;
                        r_first <= 1'b1;
                    end
                end
                S_FETCH_PC: begin
                    if (!w_step_hold) begin
                        r_state <= S_FETCH_INST;
                        r_first <= 1'b0;
                    end
                end
                S_FETCH_INST: r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= bus.opcode;
                    case (bus.opcode)
                        OP_NOP:  r_state <= S_FETCH_PC;
                        OP_ALU:  r_state <= S_ALU_EXEC;
                        OP_LD:   r_state <= S_SET_MAR;
                        OP_ST:   r_state <= S_SET_MAR;
                        OP_MOV:  r_state <= S_MOVE_REG;
                        OP_JMP:  r_state <= S_JUMP;
                        OP_MOUT: r_state <= S_SET_MAR;
                        OP_ROUT: r_state <= S_ROUT_STORE;
                        OP_HALT: r_state <= S_HALT;
                        default: begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end
                    endcase
                end
                S_ALU_EXEC: r_state <= S_ALU_OUT;
                S_SET_MAR: begin
                    case (r_op)
                        OP_LD:   r_state <= S_SET_REG;
                        OP_ST:   r_state <= S_SET_MEM;
                        OP_MOUT: r_state <= S_MOUT_STORE;
                        default: r_state <= S_FETCH_PC;
                    endcase
                end
                S_ALU_OUT, S_SET_REG, S_SET_MEM, S_MOVE_REG,
                S_JUMP, S_MOUT_STORE, S_ROUT_STORE: r_state <= S_FETCH_PC;
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_ctrl = 16'h0000;
        case (r_state)
            S_FETCH_PC: begin
                w_ctrl[B_CO] = 1'b1;
                w_ctrl[B_MI] = 1'b1;
            end
            S_FETCH_INST: begin
                w_ctrl[B_RO] = 1'b1;
                w_ctrl[B_II] = 1'b1;
                w_ctrl[B_CI] = 1'b1;
            end
            S_ALU_EXEC: w_ctrl[B_EE] = 1'b1;
            S_ALU_OUT: begin
                w_ctrl[B_EO]  = 1'b1;
                w_ctrl[B_RFI] = 1'b1;
            end
            S_SET_MAR: begin
                w_ctrl[B_DA] = 1'b1;
                w_ctrl[B_MI] = 1'b1;
            end
            S_SET_REG: begin
                w_ctrl[B_RO]  = 1'b1;
                w_ctrl[B_RFI] = 1'b1;
            end
            S_SET_MEM: begin
                w_ctrl[B_RFO] = 1'b1;
                w_ctrl[B_RI]  = 1'b1;
            end
            S_MOVE_REG: begin
                w_ctrl[B_RFO] = 1'b1;
                w_ctrl[B_RFI] = 1'b1;
            end
            S_JUMP: begin
                w_ctrl[B_CI] = 1'b1;
                w_ctrl[B_RO] = w_ja;
                w_ctrl[B_CS] = w_ja;
            end
            S_MOUT_STORE: begin
                w_ctrl[B_RO] = 1'b1;
                w_ctrl[B_GO] = 1'b1;
            end
            S_ROUT_STORE: begin
                w_ctrl[B_RFO] = 1'b1;
                w_ctrl[B_GO]  = 1'b1;
            end
            S_HALT, S_FAULT: w_ctrl[B_HALT] = 1'b1;
            default: w_ctrl = 16'h0000;
        endcase
    end

    assign bus.ctrl    = w_ctrl;
    assign bus.state_o = r_state;
    assign bus.busy    = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_FAULT);
    assign bus.fault   = r_fault;

endmodule

`default_nettype wire
